// File: rtl/swap_tim_gen_pkg.sv
// Shared definitions for the swap timing generator.
// Latency: none (types and constants only).
// Backpressure: none.
package swap_tim_gen_pkg;

    // Width of every line-timing quantity, counted in pixel ticks
    localparam int TW          = 12;
    // Default number of clk cycles per pixel tick
    localparam int CLK_DIV_DEF = 4;

    typedef logic [TW-1:0] tval_t;
    typedef logic [TW:0]   tsum_t;

    // Zero-extend both operands so the data-enable window edges are compared without wrap
    function automatic tsum_t tsum(input tsum_t a, input tval_t b);
        return a + {1'b0, b};
    endfunction

endpackage

// File: rtl/swap_tim_gen_if.sv
// Timing-parameter inputs, host swap request and video timing outputs.
// Latency: none (wiring only).
// Backpressure: none; every signal is level based.
interface swap_tim_gen_if;
    import swap_tim_gen_pkg::*;

    tval_t Thsync;
    tval_t Tgdel;
    tval_t Tgate;
    tval_t Thlen;
    logic  buf_swap;
    logic  pclk;
    logic  pclk_ena;
    logic  hsync;
    logic  vsync;
    logic  daten;

    // Host / display side: supplies timing and the swap request, consumes the timing outputs
    modport master (
        output Thsync, Tgdel, Tgate, Thlen, buf_swap,
        input  pclk, pclk_ena, hsync, vsync, daten
    );

    // Generator side
    modport slave (
        input  Thsync, Tgdel, Tgate, Thlen, buf_swap,
        output pclk, pclk_ena, hsync, vsync, daten
    );

endinterface

// File: rtl/swap_tim_gen_video_clkgen.sv
// Pixel clock divider: pclk square-ish wave and a one-clk pclk_ena strobe.
// Latency: first pclk_ena CLK_DIV clks after reset release; both outputs registered.
// Backpressure: none; free running.
module video_clkgen
    import swap_tim_gen_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic pclk,
    output logic pclk_ena
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DHALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] dcnt;

    // Divider count plus registered strobe/clock derived from the count before it advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt     <= '0;
            pclk     <= 1'b0;
            pclk_ena <= 1'b0;
        end else begin
            dcnt     <= (dcnt == DLAST) ? '0 : dcnt + DW'(1);
            pclk_ena <= (dcnt == DLAST);
            pclk     <= (dcnt < DHALF);
        end
    end

endmodule

// File: rtl/swap_tim_gen.sv
// Line timing generator with host buffer-swap driven single-line vsync.
// Latency: outputs registered one pixel tick after the hcnt they reflect.
// Backpressure: none; buf_swap is a level request, edges are remembered until the next line wrap.
module swap_tim_gen
    import swap_tim_gen_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    swap_tim_gen_if.slave tim
);

    logic  pclk_i;
    logic  tick;

    tval_t Thsync_l, Tgdel_l, Tgate_l, Thlen_l;
    tval_t hcnt;
    tsum_t hcnt_inc;
    logic  wrap;
    tsum_t de_start;
    tsum_t de_end;

    logic  sync1, sync2, sync_q;
    logic  swap_edge;
    logic  swap_pend;
    logic  vline;

    logic  hsync_q, vsync_q, daten_q;

    video_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pclk     (pclk_i),
        .pclk_ena (tick)
    );

    // Wrap decision; with the latched length still zero after reset the first tick wraps too,
    // which is what loads the timing inputs and starts line 0
    always_comb begin
        hcnt_inc = {1'b0, hcnt} + tsum_t'(1);
        wrap     = (hcnt_inc >= {1'b0, Thlen_l});
        de_start = tsum({1'b0, Thsync_l}, Tgdel_l);
        de_end   = tsum(de_start, Tgate_l);
    end

    // Line counter and per-line snapshot of the timing inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            Thsync_l <= '0;
            Tgdel_l  <= '0;
            Tgate_l  <= '0;
            Thlen_l  <= '0;
        end else if (tick) begin
            if (wrap) begin
                hcnt     <= '0;
                Thsync_l <= tim.Thsync;
                Tgdel_l  <= tim.Tgdel;
                Tgate_l  <= tim.Tgate;
                Thlen_l  <= tim.Thlen;
            end else begin
                hcnt     <= hcnt_inc[TW-1:0];
            end
        end
    end

    // Two-flop synchronizer plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync1  <= tim.buf_swap;
            sync2  <= sync1;
            sync_q <= sync2;
        end
    end

    assign swap_edge = sync2 & ~sync_q;

    // Pending swap becomes a vsync line at the next wrap; an edge on the wrap tick itself
    // re-arms the request so it is serviced one line later instead of being lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend <= 1'b0;
            vline     <= 1'b0;
        end else if (tick && wrap) begin
            vline     <= swap_pend;
            swap_pend <= swap_edge;
        end else if (swap_edge) begin
            swap_pend <= 1'b1;
        end
    end

    // Registered timing outputs from the current count; vline is the value for this line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            daten_q <= 1'b0;
        end else if (tick) begin
            hsync_q <= (hcnt < Thsync_l);
            vsync_q <= vline;
            daten_q <= ({1'b0, hcnt} >= de_start) && ({1'b0, hcnt} < de_end) && !vline;
        end
    end

    assign tim.pclk     = pclk_i;
    assign tim.pclk_ena = tick;
    assign tim.hsync    = hsync_q;
    assign tim.vsync    = vsync_q;
    assign tim.daten    = daten_q;

endmodule

// File: tb/tb_swap_tim_gen.sv
// Directed bench for swap_tim_gen with CLK_DIV=4.
// Latency: expectations measured in clks from hsync rise (4 clks per tick).
// Backpressure: not applicable.
module tb_swap_tim_gen;
    import swap_tim_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    swap_tim_gen_if tif ();

    swap_tim_gen #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tim   (tif.slave)
    );

    int errors = 0;
    int checks = 0;

    // Line measurement results, in clks relative to the hsync rise sample
    int m_hs, m_de_start, m_de, m_vs, m_period;
    // Free-run accumulators
    int r_vrise, r_vs, r_hs, r_de;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rise();
        int   n;
        bit   found;
        logic prev;
        n     = 0;
        found = 1'b0;
        prev  = tif.hsync;
        while (n < 5000 && !found) begin
            @(negedge clk);
            n++;
            if (!prev && tif.hsync) found = 1'b1;
            prev = tif.hsync;
        end
        if (!found) chk("hsync_rise_timeout", 0, 1);
    endtask

    // Starts on the sample where hsync just rose, ends on the next such sample
    task automatic measure(input int sw_on, input int sw_off, input int th_at, input int th_val);
        int   i;
        bit   done;
        logic prev;
        i = 0; done = 1'b0;
        m_hs = 0; m_de = 0; m_vs = 0; m_de_start = -1; m_period = -1;
        while (!done && i < 8000) begin
            if (i == sw_on)  tif.buf_swap = 1'b1;
            if (i == sw_off) tif.buf_swap = 1'b0;
            if (i == th_at)  tif.Thlen = tval_t'(th_val);
            if (tif.hsync) m_hs++;
            if (tif.vsync) m_vs++;
            if (tif.daten) begin
                if (m_de_start < 0) m_de_start = i;
                m_de++;
            end
            prev = tif.hsync;
            @(negedge clk);
            i++;
            if (!prev && tif.hsync) begin
                done     = 1'b1;
                m_period = i;
            end
        end
        if (!done) chk("line_timeout", 0, 1);
    endtask

    task automatic clr_counts();
        r_vrise = 0; r_vs = 0; r_hs = 0; r_de = 0;
    endtask

    task automatic run_clks(input int n);
        logic pv;
        pv = tif.vsync;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tif.vsync && !pv) r_vrise++;
            pv = tif.vsync;
            if (tif.vsync) r_vs++;
            if (tif.hsync) r_hs++;
            if (tif.daten) r_de++;
        end
    endtask

    initial begin
        logic [11:0] ena_v, pclk_v, hs_v;

        tif.Thsync   = 12'd16;
        tif.Tgdel    = 12'd4;
        tif.Tgate    = 12'd360;
        tif.Thlen    = 12'd400;
        tif.buf_swap = 1'b0;
        clr_counts();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pclk",     int'(tif.pclk),     0);
        chk("rst_pclk_ena", int'(tif.pclk_ena), 0);
        chk("rst_hsync",    int'(tif.hsync),    0);
        chk("rst_vsync",    int'(tif.vsync),    0);
        chk("rst_daten",    int'(tif.daten),    0);

        // Divider after release: strobe every 4th clk, pclk 2 high / 2 low,
        // hsync appears with the second tick (first tick only loads the timing)
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ena_v[k]  = tif.pclk_ena;
            pclk_v[k] = tif.pclk;
            hs_v[k]   = tif.hsync;
        end
        chk("div_pclk_ena_pattern", int'(ena_v),  'h888);
        chk("div_pclk_pattern",     int'(pclk_v), 'h333);
        chk("first_hsync_pattern",  int'(hs_v),   'hF00);

        // Normal line: 16/4/360/400 ticks
        wait_rise();
        measure(-1, -1, -1, 0);
        chk("line_hsync_clks",   m_hs,       64);
        chk("line_daten_start",  m_de_start, 80);
        chk("line_daten_clks",   m_de,       1440);
        chk("line_period_clks",  m_period,   1600);
        chk("line_vsync_clks",   m_vs,       0);

        // Swap request mid-line: this line unaffected
        measure(200, 600, -1, 0);
        chk("swapreq_line_vsync",  m_vs,     0);
        chk("swapreq_line_period", m_period, 1600);

        // Next line is the vsync line with no data enable
        measure(-1, -1, -1, 0);
        chk("vline_vsync_clks", m_vs,     1600);
        chk("vline_daten_clks", m_de,     0);
        chk("vline_hsync_clks", m_hs,     64);
        chk("vline_period",     m_period, 1600);

        // Following line back to normal
        measure(-1, -1, -1, 0);
        chk("post_vline_vsync", m_vs, 0);
        chk("post_vline_daten", m_de, 1440);

        // Long swap requests, four of them, each yielding exactly one vsync line
        clr_counts();
        for (int r = 0; r < 4; r++) begin
            tif.buf_swap = 1'b1;
            run_clks(800);
            tif.buf_swap = 1'b0;
            run_clks(7200);
        end
        chk("long_swap_vsync_pulses", r_vrise, 4);
        chk("long_swap_vsync_clks",   r_vs,    6400);

        // Length change mid-line takes effect on the next line; gate truncated at 300
        wait_rise();
        measure(-1, -1, 200, 300);
        chk("thlen_chg_cur_period", m_period, 1600);
        chk("thlen_chg_cur_hsync",  m_hs,     64);
        measure(-1, -1, -1, 0);
        chk("thlen_chg_next_period", m_period,   1200);
        chk("thlen_chg_next_daten",  m_de,       1120);
        chk("thlen_chg_next_start",  m_de_start, 80);

        // Zero hsync width: hsync stays low, gate now 4..299
        tif.Thsync = 12'd0;
        run_clks(1400);
        clr_counts();
        run_clks(2400);
        chk("thsync0_hsync_clks", r_hs, 0);
        chk("thsync0_daten_clks", r_de, 2368);

        // Line length 1: hcnt pinned at 0, hsync constant high, no data enable
        tif.Thsync = 12'd16;
        tif.Thlen  = 12'd1;
        run_clks(2000);
        clr_counts();
        run_clks(400);
        chk("thlen1_hsync_clks", r_hs, 400);
        chk("thlen1_daten_clks", r_de, 0);

        // Reset mid-line with a swap pending
        tif.Thlen = 12'd400;
        wait_rise();
        run_clks(200);
        tif.buf_swap = 1'b1;
        run_clks(20);
        tif.buf_swap = 1'b0;
        run_clks(10);
        chk("pre_rst_daten", int'(tif.daten), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hsync",    int'(tif.hsync),    0);
        chk("midrst_vsync",    int'(tif.vsync),    0);
        chk("midrst_daten",    int'(tif.daten),    0);
        chk("midrst_pclk",     int'(tif.pclk),     0);
        chk("midrst_pclk_ena", int'(tif.pclk_ena), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        run_clks(4000);
        chk("post_rst_no_vsync", r_vrise, 0);

        // A fresh request still works after reset
        tif.buf_swap = 1'b1;
        run_clks(40);
        tif.buf_swap = 1'b0;
        clr_counts();
        run_clks(4000);
        chk("post_rst_new_swap_pulses", r_vrise, 1);
        chk("post_rst_new_swap_clks",   r_vs,    1600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
